// File: rtl/tinyalu_pkg.sv
// Shared TinyALU definitions: operation encoding and the command record.
// Used by the command driver, its FIFO, the scoreboard and the BFM.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef struct packed {
        operation_t  op;
        logic [7:0]  A;
        logic [7:0]  B;
    } cmd_t;

    localparam logic [15:0] TIMEOUT_RESULT = 16'hDEAD;

    // Codes 5 and 6 are unused and fall through as no_op.
    function automatic logic is_alu_op(input operation_t op);
        return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
    endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous command FIFO for the TinyALU driver; DEPTH must be a power of two, >= 2.
module tinyalu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A simultaneous pop frees the slot, so push is legal even when full.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// TinyALU command initiator: buffers valid/ready commands and drives the start/done pins.
// Define TINYALU_DRV_TIMEOUT_EN to abort ISSUE after TIMEOUT_CYC cycles without alu_done.
module tinyalu_cmd_driver
    import tinyalu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_op,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    output logic        alu_reset_n,
    input  logic        alu_done,
    input  logic [15:0] alu_result
);
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, RSP, RST} state_t;

    state_t state;
    cmd_t   fifo_wdata;
    cmd_t   fifo_rdata;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;

    assign fifo_wdata.op = operation_t'(cmd_op);
    assign fifo_wdata.A  = cmd_a;
    assign fifo_wdata.B  = cmd_b;
    assign cmd_ready     = !fifo_full;
    assign fifo_push     = cmd_valid && !fifo_full;
    assign fifo_pop      = (state == IDLE) && !fifo_empty;

    tinyalu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   (fifo_wdata),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef TINYALU_DRV_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          rsp_err_q;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            alu_start   <= 1'b0;
            alu_op      <= no_op;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_reset_n <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_op      <= '0;
            rsp_result  <= '0;
`ifdef TINYALU_DRV_TIMEOUT_EN
            tmo_cnt     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (is_alu_op(fifo_rdata.op)) begin
                            alu_op    <= fifo_rdata.op;
                            alu_A     <= fifo_rdata.A;
                            alu_B     <= fifo_rdata.B;
                            alu_start <= 1'b1;
                            state     <= ISSUE;
`ifdef TINYALU_DRV_TIMEOUT_EN
                            tmo_cnt   <= '0;
`endif
                        end else if (fifo_rdata.op == rst_op) begin
                            alu_reset_n <= 1'b0;
                            alu_op      <= no_op;
                            alu_start   <= 1'b0;
                            state       <= RST;
                        end
                    end
                end
                ISSUE: begin
                    if (alu_done) begin
                        alu_start  <= 1'b0;
                        rsp_op     <= alu_op;
                        rsp_result <= alu_result;
`ifdef TINYALU_DRV_TIMEOUT_EN
                        rsp_err_q  <= 1'b0;
`endif
                        state      <= GAP;
                    end
`ifdef TINYALU_DRV_TIMEOUT_EN
                    else if (tmo_hit) begin
                        alu_start  <= 1'b0;
                        rsp_op     <= alu_op;
                        rsp_result <= TIMEOUT_RESULT;
                        rsp_err_q  <= 1'b1;
                        state      <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RST: begin
                    alu_reset_n <= 1'b1;
                    alu_op      <= no_op;
                    alu_start   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Scoreboard bench for tinyalu_cmd_driver with a behavioural TinyALU model.
// Timeout scenario runs only when TINYALU_DRV_TIMEOUT_EN is defined.
module tb_tinyalu_cmd_driver;
    import tinyalu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_op;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic        alu_reset_n;
    logic        alu_done;
    logic [15:0] alu_result;

    int tests = 0;
    int fails = 0;
    int rsp_count = 0;
    int rstn_low_cnt = 0;
    int start_hi_cnt = 0;
    logic hang = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] res;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    tinyalu_cmd_driver #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_op      (rsp_op),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_A       (alu_A),
        .alu_B       (alu_B),
        .alu_reset_n (alu_reset_n),
        .alu_done    (alu_done),
        .alu_result  (alu_result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural ALU: single-cycle ops finish one cycle after start is seen, mul after three.
    int alu_age;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_done   <= 1'b0;
            alu_result <= '0;
            alu_age    <= 0;
        end else if (!alu_reset_n) begin
            alu_done   <= 1'b0;
            alu_result <= '0;
            alu_age    <= 0;
        end else begin
            alu_done <= 1'b0;
            if (alu_start && !alu_done && !hang) begin
                if (alu_age + 1 == ((alu_op == 3'b100) ? 3 : 1)) begin
                    alu_done <= 1'b1;
                    alu_age  <= 0;
                    case (alu_op)
                        3'b001:  alu_result <= {8'h00, alu_A} + {8'h00, alu_B};
                        3'b010:  alu_result <= {8'h00, alu_A & alu_B};
                        3'b011:  alu_result <= {8'h00, alu_A ^ alu_B};
                        3'b100:  alu_result <= {8'h00, alu_A} * {8'h00, alu_B};
                        default: alu_result <= '0;
                    endcase
                end else begin
                    alu_age <= alu_age + 1;
                end
            end else begin
                alu_age <= 0;
            end
        end
    end

    // Monitor: scoreboard pops on each handshake, plus hold-stability checks.
    exp_t        e;
    logic        p_start = 1'b0;
    logic        p_done = 1'b0;
    logic        p_hold = 1'b0;
    logic [2:0]  p_op;
    logic [7:0]  p_a;
    logic [7:0]  p_b;
    logic [2:0]  p_rop;
    logic [15:0] p_res;
    always @(negedge clk) begin
        if (reset_n) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_result), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    rsp_count++;
                    check("rsp_op", 32'(rsp_op), 32'(e.op));
                    check("rsp_result", 32'(rsp_result), 32'(e.res));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            if (alu_start && p_start) begin
                check("alu_op_hold", 32'(alu_op), 32'(p_op));
                check("alu_A_hold", 32'(alu_A), 32'(p_a));
                check("alu_B_hold", 32'(alu_B), 32'(p_b));
            end
            if (p_done) begin
                check("start_drop_after_done", 32'(alu_start), 32'd0);
            end
            if (p_hold) begin
                check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                check("rsp_result_hold", 32'(rsp_result), 32'(p_res));
                check("rsp_op_hold", 32'(rsp_op), 32'(p_rop));
            end
            if (!alu_reset_n) rstn_low_cnt++;
            if (alu_start) start_hi_cnt++;
        end
        p_start = alu_start && reset_n;
        p_done  = alu_done && reset_n;
        p_hold  = rsp_valid && !rsp_ready && reset_n;
        p_op    = alu_op;
        p_a     = alu_A;
        p_b     = alu_B;
        p_rop   = rsp_op;
        p_res   = rsp_result;
    end

    task automatic expect_rsp(input logic [2:0] op, input logic [15:0] res, input logic err);
        exp_t x;
        x.op = op;
        x.res = res;
        x.err = err;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                check("cmd_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic measure_latency(input string name, input int exp_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        check(name, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        int n;
        int cnt0;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_op", 32'(rsp_op), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_A", 32'(alu_A), 32'd0);
        check("rst_alu_B", 32'(alu_B), 32'd0);
        check("rst_alu_reset_n", 32'(alu_reset_n), 32'd1);

        // Single add: push edge + 1 to pop, then 3 cycles to rsp_valid.
        @(posedge clk);
        #1;
        expect_rsp(add_op, 16'h0046, 1'b0);
        send(add_op, 8'h12, 8'h34);
        measure_latency("add_latency", 5);
        wait_drain();

        // Mul: 5 cycles from pop.
        expect_rsp(mul_op, 16'hFE01, 1'b0);
        send(mul_op, 8'hFF, 8'hFF);
        measure_latency("mul_latency", 7);
        wait_drain();

        // FIFO fill under response backpressure.
        rsp_ready = 1'b0;
        expect_rsp(add_op, 16'h0003, 1'b0);
        expect_rsp(and_op, 16'h0030, 1'b0);
        expect_rsp(xor_op, 16'h00FF, 1'b0);
        expect_rsp(mul_op, 16'h0100, 1'b0);
        expect_rsp(add_op, 16'h01FE, 1'b0);
        send(add_op, 8'h01, 8'h02);
        send(and_op, 8'hF0, 8'h3C);
        send(xor_op, 8'hAA, 8'h55);
        send(mul_op, 8'h10, 8'h10);
        send(add_op, 8'hFF, 8'hFF);
        repeat (8) @(negedge clk);
        check("fifo_full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_pending", 32'(exp_q.size()), 32'd5);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain();
        check("fifo_drained_cmd_ready", 32'(cmd_ready), 32'd1);

        // Special ops: no_op, rst_op, unused code 5, then xor.
        cnt0 = rsp_count;
        rstn_low_cnt = 0;
        expect_rsp(xor_op, 16'h00FF, 1'b0);
        send(no_op, 8'h11, 8'h22);
        send(rst_op, 8'h00, 8'h00);
        send(3'b101, 8'h33, 8'h44);
        send(xor_op, 8'hF0, 8'h0F);
        wait_drain();
        check("rst_op_low_cycles", 32'(rstn_low_cnt), 32'd1);
        check("special_rsp_count", 32'(rsp_count - cnt0), 32'd1);

        // Reset during a mul abandons it.
        cnt0 = rsp_count;
        send(mul_op, 8'h03, 8'h04);
        n = 0;
        while (!alu_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mul_issue_seen", 32'(alu_start), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_alu_start", 32'(alu_start), 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_alu_A", 32'(alu_A), 32'd0);
        check("midrst_alu_B", 32'(alu_B), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_count - cnt0), 32'd0);
        @(posedge clk);
        #1;
        expect_rsp(add_op, 16'h0002, 1'b0);
        send(add_op, 8'h01, 8'h01);
        wait_drain();

`ifdef TINYALU_DRV_TIMEOUT_EN
        hang = 1'b1;
        start_hi_cnt = 0;
        expect_rsp(add_op, 16'hDEAD, 1'b1);
        send(add_op, 8'h05, 8'h05);
        wait_drain();
        check("timeout_start_cycles", 32'(start_hi_cnt), 32'd16);
        check("timeout_start_low", 32'(alu_start), 32'd0);
        hang = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule

// File: doc/tinyalu_cmd_driver.md
Name: tinyalu_cmd_driver

Overview:
- Synthesizable command initiator for the TinyALU start/done protocol; the issuing end of the interface whose results the scoreboard checks.
- Accepts operations over a valid/ready command port and buffers them in a small FIFO.
- Sequences each operation onto the ALU pins (start/op/A/B held until done) and returns each result over a valid/ready response port.
- Sits between a test sequencer or embedded controller and the ALU DUT.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 16, cycles in ISSUE without done before abort; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  3  operation code, package enum.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_op  out  3  operation that produced the result.
- rsp_result  out  16  ALU result.
- rsp_err  out  1  result invalid (timeout); always 0 when the optional feature is off.
- alu_start  out  1  ALU start.
- alu_op  out  3  ALU op.
- alu_A  out  8  ALU operand A.
- alu_B  out  8  ALU operand B.
- alu_reset_n  out  1  ALU reset, driven low for rst_op.
- alu_done  in  1  ALU completion pulse.
- alu_result  in  16  ALU result, valid while alu_done is high.

Behaviour:
- Reset values: FIFO empty; cmd_ready=1; rsp_valid=0; rsp_op=0; rsp_result=0; rsp_err=0; alu_start=0; alu_op=no_op; alu_A=0; alu_B=0; alu_reset_n=1; FSM in IDLE.
- Reset asserted mid-operation abandons the operation: no response is produced and the FIFO is cleared.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - Push and pop in the same cycle are both allowed while full, and occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, GAP, RSP, RST.
- IDLE, FIFO not empty: pop the head.
  - add/and/xor/mul: register op, A and B onto alu_*, assert alu_start, go to ISSUE.
  - no_op: discard; no ALU activity; no response; stay in IDLE.
  - rst_op: drive alu_reset_n=0 for exactly one cycle, go to RST; no response.
  - Unused codes (5, 6): treated as no_op.
- ISSUE: alu_start, alu_op, alu_A and alu_B are held stable.
  - On a cycle with alu_done=1: capture alu_result and op into rsp_*, deassert alu_start next cycle, go to GAP.
  - Minimum latency, pop to rsp_valid: single-cycle ops 3 cycles; mul 5 cycles (ALU mul takes 3 cycles).
- GAP: alu_start=0 for one cycle, mandatory between ALU transactions.
  - Then rsp_valid=1 and go to RSP.
- RSP: hold rsp_* stable while rsp_valid && !rsp_ready.
  - On handshake: rsp_valid=0 next cycle, go to IDLE.
  - No new ALU issue while a response is pending, so the response path is backpressure-safe.
- RST: alu_reset_n=1, alu_op=no_op, alu_start=0; go to IDLE next cycle.
- alu_done outside ISSUE is ignored.
- mul result is the full 16 bits; the driver performs no arithmetic.

Optional Feature:
- Macro: TINYALU_DRV_TIMEOUT_EN.
- With the macro: a counter clears on entry to ISSUE and increments each cycle in ISSUE. When it reaches TIMEOUT_CYC without alu_done:
  - deassert alu_start;
  - respond with rsp_err=1, rsp_result=16'hDEAD;
  - proceed GAP, then RSP.
- Without the macro: no counter is built, rsp_err is tied 0, and ISSUE waits indefinitely.

Decomposition:
- tinyalu_pkg holds the operation enum, shared with the scoreboard and BFM: no_op=3'b000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111.
- tinyalu_pkg also holds a cmd_t struct {op, A, B}.
- Sub-module tinyalu_cmd_fifo: parameterized synchronous FIFO storing cmd_t, with full/empty outputs.
- The FSM and response register stay in tinyalu_cmd_driver.

Test Plan:
- Single add: A=8'h12, B=8'h34, rsp_ready=1 -> alu_start held until done; rsp_result=16'h0046, rsp_op=add_op, 3 cycles after pop.
- Mul: A=8'hFF, B=8'hFF -> rsp_result=16'hFE01; alu_A, alu_B and alu_op stable for all 3 ISSUE cycles.
- FIFO full and backpressure: push 5 commands with rsp_ready=0 -> cmd_ready=0 after 4 pushes plus 1 in flight; release rsp_ready -> results delivered in order, none lost.
- Special ops: sequence no_op, rst_op, xor(8'hF0, 8'h0F) -> no response for no_op; alu_reset_n low exactly one cycle; single response 16'h00FF.
- Reset mid-mul: assert reset_n=0 during ISSUE -> all outputs at reset values; no response; next add(1,1) returns 16'h0002.
- TINYALU_DRV_TIMEOUT_EN defined, ALU model never raises done -> after 16 cycles rsp_err=1, rsp_result=16'hDEAD, alu_start deasserted.
